// File: rtl/trace_capture.sv
// trace_capture: records WIDTH-bit probe samples into a DEPTH-entry buffer,
// then plays them back in capture order, one word per read request.
//
// Ports:
//   clk, rst          - clock; asynchronous active-low reset
//   start             - arm a capture session (IDLE only)
//   stop              - end capture early (CAPTURE only)
//   sample_valid/data - probe word to record this cycle
//   rd_en             - request the next captured word (DONE only)
//   busy / done       - CAPTURE / DONE state indicators
//   count             - number of entries captured in this session
//   overflow          - sticky: a sample arrived while in DONE
//   rd_data/valid/last- registered read-back word, pulse, final-entry flag
module trace_capture #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   sample_valid,
  input  logic [WIDTH-1:0]       sample_data,
  input  logic                   rd_en,
  output logic                   busy,
  output logic                   done,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   rd_valid,
  output logic                   rd_last
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             overflow_q, overflow_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;
  logic             rd_last_q, rd_last_d;
  logic             wr_en;
  logic [WIDTH-1:0] mem_q [DEPTH];

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    rd_last_d  = 1'b0;
    wr_en      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_CAPTURE;
          wr_ptr_d   = '0;
          rd_ptr_d   = '0;
          count_d    = '0;
          overflow_d = 1'b0;
        end
      end
      S_CAPTURE: begin
        if (sample_valid) begin
          wr_en    = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
          count_d  = count_q + 1'b1;
        end
        // A sample coinciding with stop is kept; the full write also ends capture.
        if (stop || count_d == FULL) state_d = S_DONE;
      end
      S_DONE: begin
        if (sample_valid) overflow_d = 1'b1;
        if (count_q == '0) begin
          state_d = S_IDLE;
        end else if (rd_en && {1'b0, rd_ptr_q} < count_q) begin
          rd_data_d  = mem_q[rd_ptr_q];
          rd_valid_d = 1'b1;
          rd_ptr_d   = rd_ptr_q + 1'b1;
          if ({1'b0, rd_ptr_q} == count_q - 1'b1) begin
            rd_last_d = 1'b1;
            state_d   = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      rd_last_q  <= rd_last_d;
    end
  end

  // Buffer storage is deliberately unreset; only written entries are ever read.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= sample_data;
  end

  assign busy     = (state_q == S_CAPTURE);
  assign done     = (state_q == S_DONE);
  assign count    = count_q;
  assign overflow = overflow_q;
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign rd_last  = rd_last_q;
endmodule

// File: doc/trace_capture.md
# trace_capture

Hardware trace recorder for the MIPS datapath blocks. It is the writing end of the stimulus/response vector flow: it samples a WIDTH-bit probe word (e.g. {clk, rst, d, q} of a register under observation) into an internal DEPTH-entry buffer. It then plays the captured words back one per read request, in capture order, for comparison against expected vectors. It sits beside a unit under observation and is driven by a debug controller or bench.

## Interface
Parameters:
- WIDTH, 4, bits per captured sample
- DEPTH, 8, number of buffer entries; power of two, >= 2

Ports:
- clk  in  1  single clock; all state changes on rising edge
- rst  in  1  reset, asynchronous, active-low; forces IDLE and clears all outputs and counters immediately
- start  in  1  arms capture; honoured only in IDLE
- stop  in  1  ends capture early; honoured only in CAPTURE
- sample_valid  in  1  sample_data is to be recorded this cycle
- sample_data  in  WIDTH  probe word
- rd_en  in  1  request next captured word; honoured only in DONE
- busy  out  1  high in CAPTURE
- done  out  1  high in DONE
- count  out  $clog2(DEPTH)+1  number of entries captured
- overflow  out  1  sticky: sample_valid seen in DONE
- rd_data  out  WIDTH  read-back word, registered
- rd_valid  out  1  rd_data valid this cycle
- rd_last  out  1  rd_data is the final captured entry; only with rd_valid

## Operation
- States: IDLE, CAPTURE, DONE.
- IDLE:
  - start=1 -> CAPTURE.
  - On the same edge: wr_ptr=0, rd_ptr=0, count=0, overflow=0.
  - sample_valid and rd_en are ignored.
- CAPTURE:
  - sample_valid=1 writes mem[wr_ptr]=sample_data, then wr_ptr+1 and count+1.
  - The write that makes count==DEPTH moves the block to DONE on the same edge.
  - stop=1 -> DONE. If sample_valid=1 in the same cycle, that sample is written first.
  - start is ignored.
- DONE:
  - count>0: each rd_en=1 with rd_ptr<count loads rd_data=mem[rd_ptr] and increments rd_ptr.
  - The read with rd_ptr==count-1 also sets rd_last and moves the block to IDLE on the same edge.
  - count==0: the block returns to IDLE after exactly one DONE cycle; rd_en in that cycle produces no rd_valid.
  - sample_valid=1 sets overflow (sticky until next accepted start); the data is dropped.
  - start and stop are ignored.
- Width rules:
  - wr_ptr and rd_ptr are $clog2(DEPTH) bits.
  - count is one bit wider so that DEPTH is representable.
  - No wrap-around: capture never overwrites.
- count and overflow hold their values through DONE and into IDLE until the next accepted start.
- Memory contents are not reset; nothing reads unwritten entries.

## Timing
- Reset values: busy=0, done=0, count=0, overflow=0, rd_data=0, rd_valid=0, rd_last=0, state=IDLE.
- Reset applies asynchronously mid-capture or mid-readout, and any partial session is abandoned.
- start at edge N: busy=1 from N; the first sample can be recorded at edge N+1.
- Write latency: count reflects a sample one cycle after its sample_valid cycle.
- Read latency: rd_en sampled at edge N -> rd_data/rd_valid valid after edge N, for one cycle.
- Back-to-back rd_en yields back-to-back rd_valid.
- rd_valid and rd_last are single-cycle pulses. After the last read they are asserted during the first IDLE cycle (done already 0).
- The DONE->IDLE edge accepts no start; start is honoured from the first IDLE cycle onward.

## Test plan
- Reset then start, 8 consecutive samples 0x1..0x8 -> busy for the 8 write cycles; done=1, count=8; 8 rd_en cycles return 0x1..0x8 in order, rd_last only with 0x8, then IDLE.
- Start, samples 0xA, 0x5, gap of 3 idle cycles, 0xF, then stop -> count=3; readback 0xA, 0x5, 0xF with rd_last on 0xF; a further rd_en gives no rd_valid.
- sample_valid=1 with 0xC and stop=1 in the same cycle, after 2 samples -> count=3, last read word 0xC.
- Full capture, then sample_valid during DONE -> overflow=1, count stays 8, readback unchanged; next start clears overflow.
- Start then immediate stop with no samples -> done high exactly one cycle, count=0, no rd_valid, back in IDLE.
- Assert rst low mid-capture (count=4) and mid-readout -> all outputs 0 at once, no clock needed. A subsequent start begins a fresh capture with count=0.
